song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000 -- clk cycles per duration tick; legal range >= 2.
REQ-002 Parameter GAP_TICKS, default 1 -- silent ticks inserted after every note; 0 means no gap.
REQ-003 Parameter ADDR_W, default 6 -- song ROM address width; the song holds at most 2^ADDR_W entries.
REQ-004 clk  in  1  -- system clock; the only clock.
REQ-005 rst  in  1  -- synchronous, active-high reset.
REQ-006 start  in  1  -- one-cycle request to play from entry 0; honoured only in IDLE.
REQ-007 stop  in  1  -- abort playback; honoured in every state.
REQ-008 loop_en  in  1  -- sampled at end-of-song; when 1, playback restarts at entry 0.
REQ-009 line  out  8  -- note-enable byte to the note LUT; bit0=C ... bit7=C2; registered.
REQ-010 busy  out  1  -- 1 in every state except IDLE.
REQ-011 done  out  1  -- one-cycle pulse when the song ends without looping.
REQ-012 note_idx  out  ADDR_W  -- address of the entry currently fetched or playing.

Function
REQ-013 The ROM entry is 16 bits {dur[7:0], notes[7:0]}; dur=0 marks end-of-song; notes=0x00 with dur>0 is a rest.
REQ-014 ROM read latency SHALL be 1 cycle: the address is registered in FETCH, and the data is valid in DECODE.
REQ-015 The FSM states SHALL be IDLE, FETCH, DECODE, PLAY, GAP, DONE.
REQ-016 IDLE -> FETCH on start & !stop; note_idx<=0.
REQ-017 FETCH -> DECODE unconditionally, taking 1 cycle.
REQ-018 DECODE with dur!=0 -> PLAY; line<=notes, dur_cnt<=dur, and the prescaler clears.
REQ-019 DECODE with dur=0 -> FETCH with note_idx<=0 if loop_en=1; otherwise -> DONE with line=0.
REQ-020 The prescaler counts 0..TICK_DIV-1 only in PLAY/GAP and raises tick on the wrap cycle; it clears on every PLAY/GAP entry.
REQ-021 In PLAY, dur_cnt decrements on tick; on the tick where dur_cnt=1 -> GAP (line<=0), or -> FETCH directly if GAP_TICKS=0.
REQ-022 line SHALL equal notes for exactly dur*TICK_DIV consecutive cycles per entry.
REQ-023 GAP SHALL hold line=0 for exactly GAP_TICKS*TICK_DIV cycles, then -> FETCH with note_idx+1.
REQ-024 If note_idx = 2^ADDR_W-1 when the next entry is needed, this is treated as end-of-song (REQ-019) and note_idx does not wrap silently.
REQ-025 DONE SHALL assert done for 1 cycle, then -> IDLE.
REQ-026 stop in any state: next cycle state=IDLE, line=0, busy=0, no done pulse.
REQ-027 start & stop in the same cycle: stop wins and playback does not begin.
REQ-028 start while busy is ignored and the current playback continues unchanged.
REQ-029 Gap between consecutive entries (excluding the gap itself) SHALL be exactly 2 cycles (FETCH+DECODE) of line=0 as seen before the next note; with GAP_TICKS=0, line is 0 for those 2 cycles only.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, line=0, busy=0, done=0, note_idx=0, dur_cnt=0, prescaler=0.
REQ-031 rst takes priority over start, stop and every state transition, including mid-note.

Structure
REQ-032 The shared package song_pkg holds state encoding, ROM entry field widths/offsets, the end-of-song marker value, and the note bit positions C..C2.
REQ-033 One sub-module song_rom (synchronous read, ADDR_W address, 16-bit data, contents from an init file) is instantiated inside; the prescaler and FSM stay in song_sequencer.
REQ-034 line drives the existing note-enable LUT unchanged; the sequencer has no knowledge of note frequencies.

Verification (TICK_DIV=4, GAP_TICKS=1; ROM: {2,0x01},{1,0x84},{0,xx})
REQ-035 start pulse -> line=0x01 for 8 cycles, 0x00 for 4+2 cycles, 0x84 for 4 cycles, then done pulses once; busy falls the same cycle as DONE->IDLE.
REQ-036 Same ROM with loop_en=1 -> after 0x84 + gap, line=0x01 again; done is never asserted; note_idx returns to 0.
REQ-037 stop during the 3rd cycle of 0x01 -> next cycle line=0, busy=0, done=0; a later start replays from entry 0.
REQ-038 start and stop high in the same IDLE cycle -> busy stays 0 and line stays 0.
REQ-039 rst asserted mid-PLAY -> next cycle all outputs at reset values; start while busy produces no restart (line timing identical to REQ-035).
REQ-040 A full ROM with no end marker (ADDR_W=2, all dur=1) -> 4 notes play, then done; note_idx never exceeds 3.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM encoding, ROM entry layout,
// end-of-song marker and the note bit positions on the note-enable line.
package song_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int ENTRY_W   = 16;
  localparam int NOTES_LSB = 0;
  localparam int NOTES_W   = 8;
  localparam int DUR_LSB   = 8;
  localparam int DUR_W     = 8;

  localparam logic [DUR_W-1:0] END_OF_SONG = '0;

  localparam int NOTE_C  = 0;
  localparam int NOTE_D  = 1;
  localparam int NOTE_E  = 2;
  localparam int NOTE_F  = 3;
  localparam int NOTE_G  = 4;
  localparam int NOTE_A  = 5;
  localparam int NOTE_B  = 6;
  localparam int NOTE_C2 = 7;

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
    return entry[DUR_LSB +: DUR_W];
  endfunction

  function automatic logic [NOTES_W-1:0] entry_notes(input logic [ENTRY_W-1:0] entry);
    return entry[NOTES_LSB +: NOTES_W];
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM with one-cycle synchronous read. INIT is the flattened song image
// (entry i at bits [16*i +: 16]) produced from the song's init file by the build.
module song_rom
  import song_pkg::*;
#(
  parameter int                             ADDR_W = 6,
  parameter logic [(ENTRY_W << ADDR_W)-1:0] INIT   = '0
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ENTRY_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign mem[i] = INIT[ENTRY_W*i +: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/song_sequencer.sv
// Plays a song from ROM as a timed sequence of note-enable bytes, with an
// optional silent gap after each note and optional looping at end-of-song.
//
// state  | meaning
// IDLE   | waiting for start, line silent
// FETCH  | ROM address (note_idx) registered, data arrives next cycle
// DECODE | ROM entry valid: load note and duration, or handle end-of-song
// PLAY   | line holds the note for dur ticks
// GAP    | line silent for GAP_TICKS ticks
// DONE   | one-cycle done pulse, then back to IDLE
module song_sequencer
  import song_pkg::*;
#(
  parameter int                             TICK_DIV  = 25000,
  parameter int                             GAP_TICKS = 1,
  parameter int                             ADDR_W    = 6,
  parameter logic [(ENTRY_W << ADDR_W)-1:0] ROM_INIT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [7:0]        line,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int                PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  // Gap length shares the duration counter, so GAP_TICKS is limited to 0..255.
  localparam logic [DUR_W-1:0]  GAP_LOAD = DUR_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  state_t             state, state_nx;
  logic [7:0]         line_nx;
  logic [ADDR_W-1:0]  idx_nx;
  logic [DUR_W-1:0]   cnt, cnt_nx;
  logic [PRE_W-1:0]   presc, presc_nx;
  logic [ENTRY_W-1:0] rom_data;
  logic [DUR_W-1:0]   cur_dur;
  logic [NOTES_W-1:0] cur_notes;
  logic               timing, tick, advance, song_end;

  song_rom #(
    .ADDR_W (ADDR_W),
    .INIT   (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (note_idx),
    .data (rom_data)
  );

  assign cur_dur   = entry_dur(rom_data);
  assign cur_notes = entry_notes(rom_data);
  assign timing    = (state == ST_PLAY) || (state == ST_GAP);
  assign tick      = timing && (presc == PRE_LAST);

  always_comb begin
    state_nx = state;
    line_nx  = line;
    idx_nx   = note_idx;
    cnt_nx   = cnt;
    presc_nx = (timing && !tick) ? presc + 1'b1 : '0;
    advance  = 1'b0;
    song_end = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FETCH;
          idx_nx   = '0;
        end
      end
      ST_FETCH: state_nx = ST_DECODE;
      ST_DECODE: begin
        if (cur_dur == END_OF_SONG) begin
          song_end = 1'b1;
        end else begin
          state_nx = ST_PLAY;
          line_nx  = cur_notes;
          cnt_nx   = cur_dur;
          presc_nx = '0;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (cnt == DUR_W'(1)) begin
            line_nx = '0;
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              state_nx = ST_GAP;
              cnt_nx   = GAP_LOAD;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (cnt == DUR_W'(1)) advance = 1'b1;
          else                  cnt_nx  = cnt - 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    // Running off the last ROM address ends the song rather than wrapping.
    if (advance) begin
      if (note_idx == IDX_LAST) begin
        song_end = 1'b1;
      end else begin
        state_nx = ST_FETCH;
        idx_nx   = note_idx + 1'b1;
      end
    end

    if (song_end) begin
      if (loop_en) begin
        state_nx = ST_FETCH;
        idx_nx   = '0;
      end else begin
        state_nx = ST_DONE;
        line_nx  = '0;
      end
    end

    if (stop) begin
      state_nx = ST_IDLE;
      line_nx  = '0;
      idx_nx   = note_idx;
      cnt_nx   = '0;
      presc_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      line     <= '0;
      note_idx <= '0;
      cnt      <= '0;
      presc    <= '0;
    end else begin
      state    <= state_nx;
      line     <= line_nx;
      note_idx <= idx_nx;
      cnt      <= cnt_nx;
      presc    <= presc_nx;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a timeline model predicts every change
// of {line, busy, done, note_idx}; a monitor compares each observed change.
module tb_song_sequencer;

  localparam int TD_A = 4, GAP_A = 1, AW_A = 6;
  localparam int TD_B = 2, GAP_B = 0, AW_B = 2;
  localparam logic [1023:0] ROM_A = 1024'({16'h0000, 16'h0184, 16'h0201});
  localparam logic [63:0]   ROM_B = {16'h0188, 16'h0144, 16'h0122, 16'h0111};

  typedef struct packed {
    logic [7:0] line;
    logic       busy;
    logic       done;
    logic [5:0] idx;
  } snap_t;

  typedef struct packed {
    int    t;
    snap_t s;
  } ev_t;

  logic       clk = 1'b0;
  logic [1:0] rst_v, start_v, stop_v, loop_v;
  logic [7:0] line_a, line_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [5:0] idx_a;
  logic [1:0] idx_b;

  int    cyc = 0;
  int    vectors = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  snap_t mon_prev[2];
  snap_t model_prev[2];
  ev_t   exp_a[$];
  ev_t   exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  song_sequencer #(.TICK_DIV(TD_A), .GAP_TICKS(GAP_A), .ADDR_W(AW_A), .ROM_INIT(ROM_A)) dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]), .loop_en(loop_v[0]),
    .line(line_a), .busy(busy_a), .done(done_a), .note_idx(idx_a)
  );

  song_sequencer #(.TICK_DIV(TD_B), .GAP_TICKS(GAP_B), .ADDR_W(AW_B), .ROM_INIT(ROM_B)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]), .loop_en(loop_v[1]),
    .line(line_b), .busy(busy_b), .done(done_b), .note_idx(idx_b)
  );

  function automatic snap_t mk(input int ln, input bit b, input bit d, input int idx);
    snap_t s;
    s.line = ln[7:0];
    s.busy = b;
    s.done = d;
    s.idx  = idx[5:0];
    return s;
  endfunction

  // Timeline of one playback: snapshot k is what is seen after clock edge e+k.
  task automatic model(input int w, input int e, input int stop_e, input bit loop,
                       input bit use_rst, output int len);
    snap_t sq[$];
    snap_t prev;
    logic [15:0] ent;
    int td, gap, last, kmax, idx, dur;
    bit eos;
    ev_t ev;
    td   = (w == 0) ? TD_A : TD_B;
    gap  = (w == 0) ? GAP_A : GAP_B;
    last = (w == 0) ? 63 : 3;
    kmax = (stop_e > 0) ? stop_e - e : 100000;
    idx  = 0;
    while (sq.size() < kmax) begin
      sq.push_back(mk(0, 1, 0, idx));
      sq.push_back(mk(0, 1, 0, idx));
      ent = (w == 0) ? ROM_A[16*idx +: 16] : ROM_B[16*idx +: 16];
      dur = int'(ent[15:8]);
      eos = 1'b0;
      if (dur == 0) begin
        eos = 1'b1;
      end else begin
        for (int i = 0; i < dur * td; i++) sq.push_back(mk(int'(ent[7:0]), 1, 0, idx));
        for (int i = 0; i < gap * td; i++) sq.push_back(mk(0, 1, 0, idx));
        if (idx == last) eos = 1'b1;
        else idx++;
      end
      if (eos) begin
        if (loop) begin
          idx = 0;
        end else begin
          sq.push_back(mk(0, 1, 1, idx));
          sq.push_back(mk(0, 0, 0, idx));
          break;
        end
      end
    end
    if (stop_e > 0) begin
      while (sq.size() > kmax) void'(sq.pop_back());
      while (sq.size() < kmax) sq.push_back(sq[sq.size()-1]);
      sq.push_back(mk(0, 0, 0, use_rst ? 0 : int'(sq[sq.size()-1].idx)));
    end
    prev = model_prev[w];
    foreach (sq[k]) begin
      if (sq[k] != prev || sq[k].done) begin
        ev.t = e + k;
        ev.s = sq[k];
        if (w == 0) exp_a.push_back(ev);
        else        exp_b.push_back(ev);
      end
      prev = sq[k];
    end
    model_prev[w] = prev;
    len = sq.size();
  endtask

  task automatic observe(input int w, input snap_t s);
    ev_t ex;
    int  pending;
    if (s == mon_prev[w] && !s.done) return;
    mon_prev[w] = s;
    vectors++;
    pending = (w == 0) ? exp_a.size() : exp_b.size();
    if (pending == 0) begin
      errors++;
      $display("FAIL unexpected_change dut%0d: t=%0d got line=%h busy=%b done=%b idx=%0d, required no change",
               w, cyc, s.line, s.busy, s.done, s.idx);
      return;
    end
    if (w == 0) ex = exp_a.pop_front();
    else        ex = exp_b.pop_front();
    if (ex.t != cyc || ex.s != s) begin
      errors++;
      $display("FAIL event dut%0d: got t=%0d line=%h busy=%b done=%b idx=%0d, required t=%0d line=%h busy=%b done=%b idx=%0d",
               w, cyc, s.line, s.busy, s.done, s.idx, ex.t, ex.s.line, ex.s.busy, ex.s.done, ex.s.idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      observe(0, {line_a, busy_a, done_a, idx_a});
      observe(1, {line_b, busy_b, done_b, 4'b0000, idx_b});
    end
  end

  task automatic check_val(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic session(input int w, input bit loop, input int stop_off,
                         input bit use_rst, input int n_extra);
    int e, stop_e, len, pending;
    int extra[$];
    repeat ($urandom_range(1, 4)) @(negedge clk);
    e      = cyc + 1;
    stop_e = (stop_off > 0) ? e + stop_off : 0;
    model(w, e, stop_e, loop, use_rst, len);
    loop_v[w]  = loop;
    start_v[w] = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0;
    if (len >= 4)
      for (int i = 0; i < n_extra; i++) extra.push_back(e + $urandom_range(1, len - 2));
    while (cyc < e + len + 1) begin
      if (cyc + 1 == stop_e) begin
        if (use_rst) rst_v[w]  = 1'b1;
        else         stop_v[w] = 1'b1;
      end
      foreach (extra[j]) if (extra[j] == cyc + 1) start_v[w] = 1'b1;
      @(negedge clk);
      rst_v[w]   = 1'b0;
      stop_v[w]  = 1'b0;
      start_v[w] = 1'b0;
    end
    loop_v[w] = 1'b0;
    pending = (w == 0) ? exp_a.size() : exp_b.size();
    vectors++;
    if (pending != 0) begin
      errors++;
      $display("FAIL missing_events dut%0d: got %0d events still pending at t=%0d, required 0",
               w, pending, cyc);
      if (w == 0) exp_a.delete();
      else        exp_b.delete();
    end
  endtask

  initial begin
    int so;
    bit lp, ur;
    start_v = '0;
    stop_v  = '0;
    loop_v  = '0;
    rst_v   = 2'b11;
    repeat (3) @(negedge clk);
    rst_v = 2'b00;
    @(negedge clk);
    check_val("reset_line_a", int'(line_a), 0);
    check_val("reset_busy_a", int'(busy_a), 0);
    check_val("reset_done_a", int'(done_a), 0);
    check_val("reset_idx_a",  int'(idx_a),  0);
    check_val("reset_line_b", int'(line_b), 0);
    check_val("reset_busy_b", int'(busy_b), 0);
    check_val("reset_done_b", int'(done_b), 0);
    check_val("reset_idx_b",  int'(idx_b),  0);
    mon_prev[0]   = '0;
    mon_prev[1]   = '0;
    model_prev[0] = '0;
    model_prev[1] = '0;
    mon_en = 1'b1;

    session(0, 0, 0, 0, 0);                          // plain playback
    session(0, 0, 5, 0, 0);                          // stop in 3rd cycle of first note
    session(0, 0, 0, 0, 0);                          // replay after stop

    @(negedge clk);
    start_v[0] = 1'b1;
    stop_v[0]  = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    stop_v[0]  = 1'b0;
    @(negedge clk);
    check_val("start_stop_busy", int'(busy_a), 0);
    check_val("start_stop_line", int'(line_a), 0);

    session(0, 1, $urandom_range(60, 90), 0, 0);     // looping
    session(0, 0, $urandom_range(3, 10), 1, 0);      // reset mid-note
    session(0, 0, 0, 0, 3);                          // start while busy is ignored
    session(1, 0, 0, 0, 0);                          // full ROM without end marker
    session(1, 1, $urandom_range(20, 40), 0, 2);     // full ROM looping

    for (int n = 0; n < 14; n++) begin
      lp = $urandom_range(0, 1);
      if (lp) so = $urandom_range(20, 80);
      else    so = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 30) : 0;
      ur = (so > 0) && ($urandom_range(0, 3) == 0);
      session(n % 2, lp, so, ur, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run by t=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
